hamming_merge2: RTL and testbench

//   Ordered two-way merge stage for the Hamming dataflow network. Pulls the head

---
 rtl/hamming_merge2.sv | 178 +++++++++++++++++
 tb/tb_hamming_merge2.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_merge2.sv
// Ordered two-way merge for the Hamming dataflow network.
// Pulls one head word from each of two upstream FIFOs, emits the smaller one
// downstream, and collapses equal heads into a single output word.
//
// state   | meaning
// --------+-----------------------------------------------------------
// FILL    | fetch a head from every side whose head register is empty
// COMPARE | both heads valid; latch min(a_head, b_head) and the selection
// PUT     | offer the latched word downstream until it is accepted
//
// All handshake outputs are registered. Their next value comes from the
// next state, so a request drops on the same edge that completes it. The
// out request and the get requests can never be high in the same cycle.
module hamming_merge2 #(
    parameter int WORD_SIZE = 16
) (
    input  logic                 clock,
    input  logic                 clear_n,
    output logic                 a_get_req,
    input  logic                 a_get_ack,
    input  logic [WORD_SIZE-1:0] a_get_value,
    output logic                 b_get_req,
    input  logic                 b_get_ack,
    input  logic [WORD_SIZE-1:0] b_get_value,
    output logic                 out_put_req,
    input  logic                 out_put_ack,
    output logic [WORD_SIZE-1:0] out_put_value,
    output logic [15:0]          dup_count,
    output logic                 order_error
);

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        COMPARE = 2'd1,
        PUT     = 2'd2
    } state_t;

    state_t               state_q, state_d;

    logic [WORD_SIZE-1:0] a_head_q, a_head_d;
    logic                 a_valid_q, a_valid_d;
    logic [WORD_SIZE-1:0] a_last_q, a_last_d;
    logic                 a_seen_q, a_seen_d;

    logic [WORD_SIZE-1:0] b_head_q, b_head_d;
    logic                 b_valid_q, b_valid_d;
    logic [WORD_SIZE-1:0] b_last_q, b_last_d;
    logic                 b_seen_q, b_seen_d;

    logic [WORD_SIZE-1:0] out_value_q, out_value_d;
    logic                 sel_a_q, sel_a_d;
    logic                 sel_b_q, sel_b_d;
    logic [15:0]          dup_q, dup_d;
    logic                 err_q, err_d;

    logic                 a_req_q, a_req_d;
    logic                 b_req_q, b_req_d;
    logic                 out_req_q, out_req_d;

    logic                 a_fire;
    logic                 b_fire;
    logic                 out_fire;

    assign a_fire   = a_req_q & a_get_ack;
    assign b_fire   = b_req_q & b_get_ack;
    assign out_fire = out_req_q & out_put_ack;

    // State register and all datapath/handshake registers, synchronous clear.
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            state_q     <= FILL;
            a_head_q    <= '0;
            a_valid_q   <= 1'b0;
            a_last_q    <= '0;
            a_seen_q    <= 1'b0;
            b_head_q    <= '0;
            b_valid_q   <= 1'b0;
            b_last_q    <= '0;
            b_seen_q    <= 1'b0;
            out_value_q <= '0;
            sel_a_q     <= 1'b0;
            sel_b_q     <= 1'b0;
            dup_q       <= '0;
            err_q       <= 1'b0;
            a_req_q     <= 1'b0;
            b_req_q     <= 1'b0;
            out_req_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_head_q    <= a_head_d;
            a_valid_q   <= a_valid_d;
            a_last_q    <= a_last_d;
            a_seen_q    <= a_seen_d;
            b_head_q    <= b_head_d;
            b_valid_q   <= b_valid_d;
            b_last_q    <= b_last_d;
            b_seen_q    <= b_seen_d;
            out_value_q <= out_value_d;
            sel_a_q     <= sel_a_d;
            sel_b_q     <= sel_b_d;
            dup_q       <= dup_d;
            err_q       <= err_d;
            a_req_q     <= a_req_d;
            b_req_q     <= b_req_d;
            out_req_q   <= out_req_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (a_valid_q && b_valid_q) state_d = COMPARE;
            COMPARE: state_d = PUT;
            PUT:     if (out_fire) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // Head capture, order check, compare/select and consume on accept.
    always_comb begin
        a_head_d    = a_head_q;
        a_valid_d   = a_valid_q;
        a_last_d    = a_last_q;
        a_seen_d    = a_seen_q;
        b_head_d    = b_head_q;
        b_valid_d   = b_valid_q;
        b_last_d    = b_last_q;
        b_seen_d    = b_seen_q;
        out_value_d = out_value_q;
        sel_a_d     = sel_a_q;
        sel_b_d     = sel_b_q;
        dup_d       = dup_q;
        err_d       = err_q;

        if (a_fire) begin
            a_head_d  = a_get_value;
            a_valid_d = 1'b1;
            a_last_d  = a_get_value;
            a_seen_d  = 1'b1;
            if (a_seen_q && (a_get_value <= a_last_q)) err_d = 1'b1;
        end
        if (b_fire) begin
            b_head_d  = b_get_value;
            b_valid_d = 1'b1;
            b_last_d  = b_get_value;
            b_seen_d  = 1'b1;
            if (b_seen_q && (b_get_value <= b_last_q)) err_d = 1'b1;
        end

        if (state_q == COMPARE) begin
            sel_a_d     = (a_head_q <= b_head_q);
            sel_b_d     = (b_head_q <= a_head_q);
            out_value_d = (a_head_q <= b_head_q) ? a_head_q : b_head_q;
        end

        if ((state_q == PUT) && out_fire) begin
            if (sel_a_q) a_valid_d = 1'b0;
            if (sel_b_q) b_valid_d = 1'b0;
            if (sel_a_q && sel_b_q) dup_d = dup_q + 16'd1;
        end
    end

    // Registered handshake requests derived from where the FSM is heading.
    always_comb begin
        a_req_d   = (state_d == FILL) && !a_valid_d;
        b_req_d   = (state_d == FILL) && !b_valid_d;
        out_req_d = (state_d == PUT);
    end

    assign a_get_req     = a_req_q;
    assign b_get_req     = b_req_q;
    assign out_put_req   = out_req_q;
    assign out_put_value = out_value_q;
    assign dup_count     = dup_q;
    assign order_error   = err_q;

endmodule

// File: tb/tb_hamming_merge2.sv
// Self-checking bench for hamming_merge2: FIFO/sink models, a merge reference
// model built from queues, directed scenarios and randomized streams.
module tb_hamming_merge2;

    localparam int W = 16;

    logic         clock = 1'b0;
    logic         clear_n = 1'b0;
    logic         a_get_req, b_get_req, out_put_req;
    logic         a_get_ack = 1'b0, b_get_ack = 1'b0, out_put_ack = 1'b0;
    logic [W-1:0] a_get_value = '0, b_get_value = '0;
    logic [W-1:0] out_put_value;
    logic [15:0]  dup_count;
    logic         order_error;

    int tests = 0;
    int fails = 0;

    int unsigned fa[$];
    int unsigned fb[$];
    int unsigned exp_v[$];
    bit          exp_d[$];
    int unsigned got[$];
    int          fire_cyc[$];

    bit          zero_wait = 1'b1;
    bit          sink_block = 1'b0;
    bit          hold_arm = 1'b0;
    int          hold_left = 0;
    int unsigned held_val = 0;

    bit          rst_next = 1'b0;
    bit          prev_clr = 1'b0;
    bit          prev_af = 1'b0, prev_bf = 1'b0, prev_of = 1'b0;
    int unsigned prev_ov = 0;
    int          cyc = 0;

    int unsigned exp_dup = 0;
    bit          exp_err = 1'b0;
    int unsigned a_last = 0, b_last = 0;
    bit          a_seen = 1'b0, b_seen = 1'b0;

    hamming_merge2 #(.WORD_SIZE(W)) dut (
        .clock        (clock),
        .clear_n      (clear_n),
        .a_get_req    (a_get_req),
        .a_get_ack    (a_get_ack),
        .a_get_value  (a_get_value),
        .b_get_req    (b_get_req),
        .b_get_ack    (b_get_ack),
        .b_get_value  (b_get_value),
        .out_put_req  (out_put_req),
        .out_put_ack  (out_put_ack),
        .out_put_value(out_put_value),
        .dup_count    (dup_count),
        .order_error  (order_error)
    );

    initial forever #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference merge: repeatedly compare the two stream heads, emit the
    // smaller, consume the equal pair once. Stops when a side runs dry.
    task automatic build_expected();
        int unsigned qa[$];
        int unsigned qb[$];
        qa = fa;
        qb = fb;
        exp_v.delete();
        exp_d.delete();
        while (qa.size() > 0 && qb.size() > 0) begin
            if (qa[0] < qb[0]) begin
                exp_v.push_back(qa.pop_front()); exp_d.push_back(1'b0);
            end else if (qb[0] < qa[0]) begin
                exp_v.push_back(qb.pop_front()); exp_d.push_back(1'b0);
            end else begin
                exp_v.push_back(qa.pop_front()); exp_d.push_back(1'b1);
                void'(qb.pop_front());
            end
        end
    endtask

    // One cycle: account for the transfers of the last edge, compare, drive.
    task automatic tick();
        int unsigned v;
        @(negedge clock);
        cyc++;
        if (!prev_clr) begin
            exp_dup = 0; exp_err = 1'b0;
            a_seen = 1'b0; b_seen = 1'b0; a_last = 0; b_last = 0;
            check("rst_a_req", a_get_req, 0);
            check("rst_b_req", b_get_req, 0);
            check("rst_out_req", out_put_req, 0);
            check("rst_out_value", out_put_value, 0);
        end else begin
            if (prev_af && fa.size() > 0) begin
                v = fa.pop_front();
                if (a_seen && v <= a_last) exp_err = 1'b1;
                a_last = v; a_seen = 1'b1;
            end
            if (prev_bf && fb.size() > 0) begin
                v = fb.pop_front();
                if (b_seen && v <= b_last) exp_err = 1'b1;
                b_last = v; b_seen = 1'b1;
            end
            if (prev_of) begin
                if (exp_v.size() == 0) begin
                    check("unexpected_output", prev_ov, 32'hFFFF_FFFF);
                end else begin
                    v = exp_v.pop_front();
                    check("out_value", prev_ov, v);
                    if (exp_d.pop_front()) exp_dup = (exp_dup + 1) & 32'hFFFF;
                    got.push_back(prev_ov);
                    fire_cyc.push_back(cyc);
                end
            end
        end
        check("dup_count", dup_count, exp_dup);
        check("order_error", order_error, exp_err);
        check("req_exclusive", out_put_req && (a_get_req || b_get_req), 0);

        clear_n = rst_next;
        a_get_ack = a_get_req && (fa.size() > 0) && (zero_wait || ($urandom_range(1, 0) == 1));
        a_get_value = a_get_ack ? W'(fa[0]) : W'($urandom);
        b_get_ack = b_get_req && (fb.size() > 0) && (zero_wait || ($urandom_range(1, 0) == 1));
        b_get_value = b_get_ack ? W'(fb[0]) : W'($urandom);

        if (hold_left > 0) begin
            check("hold_out_req", out_put_req, 1);
            check("hold_out_value", out_put_value, held_val);
            check("hold_no_get", a_get_req || b_get_req, 0);
            out_put_ack = 1'b0;
            hold_left--;
        end else if (hold_arm && out_put_req) begin
            held_val = out_put_value;
            hold_left = 9;
            hold_arm = 1'b0;
            out_put_ack = 1'b0;
        end else begin
            out_put_ack = out_put_req && !sink_block &&
                          (zero_wait || ($urandom_range(2, 0) != 0));
        end

        prev_clr = clear_n;
        prev_af = a_get_req && a_get_ack && clear_n;
        prev_bf = b_get_req && b_get_ack && clear_n;
        prev_of = out_put_req && out_put_ack && clear_n;
        prev_ov = out_put_value;
    endtask

    task automatic run_test(input string name, input int unsigned qa[$],
                            input int unsigned qb[$], input bit zw);
        int  n;
        bit  seen_req;
        zero_wait = zw;
        rst_next = 1'b0;
        repeat (3) tick();
        fa = qa;
        fb = qb;
        build_expected();
        got.delete();
        fire_cyc.delete();
        rst_next = 1'b1;
        n = 0;
        seen_req = 1'b0;
        while ((exp_v.size() > 0 || prev_of) && n < 2000) begin
            tick();
            n++;
            if (!seen_req && (a_get_req || b_get_req)) begin
                check({name, "_fresh_fill"}, {a_get_req, b_get_req}, 2'b11);
                seen_req = 1'b1;
            end
        end
        if (exp_v.size() > 0) check({name, "_timeout"}, exp_v.size(), 0);
        repeat (6) tick();
    endtask

    task automatic compare_got(input string name, input int unsigned lit[$]);
        check({name, "_count"}, got.size(), lit.size());
        for (int i = 0; i < lit.size() && i < got.size(); i++)
            check({name, "_word"}, got[i], lit[i]);
    endtask

    initial begin
        int unsigned qa[$];
        int unsigned qb[$];
        int unsigned lit[$];
        int unsigned va, vb;
        int n;

        // Reset held for three cycles (reset values checked inside tick).
        rst_next = 1'b0;
        repeat (3) tick();
        check("reset_dup", dup_count, 0);
        check("reset_err", order_error, 0);

        // Interleave with zero-wait FIFOs; also pins the 4-cycle word period.
        qa = '{1, 3, 5, 100}; qb = '{2, 4, 6};
        run_test("interleave", qa, qb, 1'b1);
        lit = '{1, 2, 3, 4, 5, 6};
        compare_got("interleave", lit);
        check("interleave_dup", dup_count, 0);
        for (int i = 1; i < fire_cyc.size(); i++)
            check("word_period", fire_cyc[i] - fire_cyc[i-1], 4);

        // Duplicates collapse once.
        qa = '{2, 4, 6, 8, 100}; qb = '{3, 6, 9};
        run_test("dups", qa, qb, 1'b1);
        lit = '{2, 3, 4, 6, 8, 9};
        compare_got("dups", lit);
        check("dups_dup", dup_count, 1);

        // Back-pressure on the first PUT, random FIFO waits.
        hold_arm = 1'b1;
        qa = '{10, 20, 30, 40, 100}; qb = '{15, 25, 35};
        run_test("backpressure", qa, qb, 1'b0);
        lit = '{10, 15, 20, 25, 30, 35};
        compare_got("backpressure", lit);
        check("hold_consumed", hold_arm, 0);

        // Order error is sticky, merging continues.
        qa = '{5, 4}; qb = '{10};
        run_test("order", qa, qb, 1'b1);
        lit = '{5, 4};
        compare_got("order", lit);
        check("order_err_set", order_error, 1);
        repeat (5) tick();
        check("order_err_sticky", order_error, 1);

        // Reset while the output request is high.
        zero_wait = 1'b1;
        rst_next = 1'b0;
        repeat (3) tick();
        fa = '{1, 3}; fb = '{2};
        build_expected();
        sink_block = 1'b1;
        rst_next = 1'b1;
        n = 0;
        while (!out_put_req && n < 50) begin tick(); n++; end
        check("midput_reached", out_put_req, 1);
        rst_next = 1'b0;
        tick();
        tick();
        check("midput_req_low", out_put_req, 0);
        check("midput_get_low", a_get_req || b_get_req, 0);
        sink_block = 1'b0;
        qa = '{7, 9}; qb = '{8, 100};
        run_test("after_reset", qa, qb, 1'b1);
        lit = '{7, 8, 9};
        compare_got("after_reset", lit);

        // Randomized streams, mostly increasing with occasional repeats.
        for (int t = 0; t < 20; t++) begin
            qa.delete(); qb.delete();
            va = $urandom_range(20, 0);
            vb = $urandom_range(20, 0);
            for (int k = 0; k < int'($urandom_range(12, 1)); k++) begin
                qa.push_back(va);
                va += ($urandom_range(9, 0) == 0) ? 0 : $urandom_range(4, 1);
            end
            for (int k = 0; k < int'($urandom_range(12, 1)); k++) begin
                qb.push_back(vb);
                vb += ($urandom_range(9, 0) == 0) ? 0 : $urandom_range(4, 1);
            end
            hold_arm = ($urandom_range(3, 0) == 0);
            run_test("random", qa, qb, $urandom_range(1, 0) == 1);
            hold_arm = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
